// File: rtl/cva6_axi_rd_arbiter.sv
// cva6_axi_rd_arbiter
// Shares the single AXI shim read channel between two refill requesters:
// port 0 is the I$ refill path, port 1 is the PTW/bypass path. Each port owns
// a one-entry request buffer. One burst is outstanding at a time, and ownership
// alternates round-robin when both ports are waiting. Returning beats are
// routed to the owning port by sel_q alone.
module cva6_axi_rd_arbiter #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned BlenWidth = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    // requester side
    input  logic [1:0]                     req_i,
    output logic [1:0]                     ack_o,
    input  logic [1:0][AddrWidth-1:0]      addr_i,
    input  logic [1:0][BlenWidth-1:0]      blen_i,
    input  logic [1:0][1:0]                size_i,
    input  logic [1:0][IdWidth-1:0]        id_i,
    output logic [1:0]                     rsp_valid_o,
    output logic                           rsp_last_o,
    output logic [DataWidth-1:0]           rsp_data_o,
    output logic [IdWidth-1:0]             rsp_id_o,
    // shim side
    output logic                           rd_req_o,
    input  logic                           rd_gnt_i,
    output logic [AddrWidth-1:0]           rd_addr_o,
    output logic [BlenWidth-1:0]           rd_blen_o,
    output logic [1:0]                     rd_size_o,
    output logic [IdWidth-1:0]             rd_id_o,
    output logic                           rd_rdy_o,
    input  logic                           rd_valid_i,
    input  logic                           rd_last_i,
    input  logic [DataWidth-1:0]           rd_data_i,
    input  logic [IdWidth-1:0]             rd_id_i,
    // status
    output logic                           busy_o,
    output logic                           stray_o
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StBurst
    } state_e;

    state_e state_q;

    // Port that owns the current request/burst, and the port served last.
    logic sel_q;
    logic last_q;

    // Registered channel handshakes; they track StReq / StBurst exactly.
    logic rd_req_q;
    logic rd_rdy_q;

    // Per-port one-entry request buffers.
    logic [1:0]                buf_vld_q;
    logic [1:0][AddrWidth-1:0] buf_addr_q;
    logic [1:0][BlenWidth-1:0] buf_blen_q;
    logic [1:0][1:0]           buf_size_q;
    logic [1:0][IdWidth-1:0]   buf_id_q;

    logic [1:0] ack;
    logic       gnt;
    logic       winner;
    logic       burst_done;

    // A port is accepted only while its buffer is empty; a buffer being
    // granted in this very cycle still counts as full.
    assign ack = req_i & ~buf_vld_q;

    // rd_req_q is high exactly in StReq, so this is "granted while requesting".
    assign gnt = rd_req_q & rd_gnt_i;

    // rd_rdy_q is high exactly in StBurst.
    assign burst_done = rd_rdy_q & rd_valid_i & rd_last_i;

    // Arbitration: a lone waiter wins; on a tie the port not served last wins.
    always_comb begin
        winner = buf_vld_q[1];
        if (&buf_vld_q) begin
            winner = ~last_q;
        end
    end

    // Request buffers: capture on ack, release when the owning request is granted.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            buf_vld_q  <= '0;
            buf_addr_q <= '0;
            buf_blen_q <= '0;
            buf_size_q <= '0;
            buf_id_q   <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (ack[i]) begin
                    buf_vld_q[i]  <= 1'b1;
                    buf_addr_q[i] <= addr_i[i];
                    buf_blen_q[i] <= blen_i[i];
                    buf_size_q[i] <= size_i[i];
                    buf_id_q[i]   <= id_i[i];
                end else if (gnt && (int'(sel_q) == i)) begin
                    buf_vld_q[i]  <= 1'b0;
                end
            end
        end
    end

    // Channel FSM with registered request/ready outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            sel_q    <= 1'b0;
            last_q   <= 1'b1;
            rd_req_q <= 1'b0;
            rd_rdy_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (|buf_vld_q) begin
                        state_q  <= StReq;
                        sel_q    <= winner;
                        rd_req_q <= 1'b1;
                    end
                end
                StReq: begin
                    if (rd_gnt_i) begin
                        state_q  <= StBurst;
                        rd_req_q <= 1'b0;
                        rd_rdy_q <= 1'b1;
                    end
                end
                StBurst: begin
                    if (burst_done) begin
                        state_q  <= StIdle;
                        last_q   <= sel_q;
                        rd_rdy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    rd_req_q <= 1'b0;
                    rd_rdy_q <= 1'b0;
                end
            endcase
        end
    end

    // Issued request comes straight from the owning buffer, so it holds until grant.
    assign rd_req_o  = rd_req_q;
    assign rd_addr_o = buf_addr_q[sel_q];
    assign rd_blen_o = buf_blen_q[sel_q];
    assign rd_size_o = buf_size_q[sel_q];
    assign rd_id_o   = buf_id_q[sel_q];
    assign rd_rdy_o  = rd_rdy_q;

    // Beat routing: only the owning port sees valid, and only during a burst.
    always_comb begin
        rsp_valid_o        = '0;
        rsp_valid_o[sel_q] = rd_rdy_q & rd_valid_i;
    end

    // Shared response fields pass through untouched; rd_id_i is not checked.
    assign rsp_last_o = rd_last_i;
    assign rsp_data_o = rd_data_i;
    assign rsp_id_o   = rd_id_i;

    assign ack_o   = ack;
    assign busy_o  = (state_q != StIdle) | (|buf_vld_q);
    // Beats arriving while not ready are dropped and flagged.
    assign stray_o = rd_valid_i & ~rd_rdy_q;

endmodule

// File: tb/tb_cva6_axi_rd_arbiter.sv
// Self-checking bench for cva6_axi_rd_arbiter: directed scenarios followed by
// a randomized run against a transaction-level reference model.
module tb_cva6_axi_rd_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned IW = 4;
    localparam int unsigned BW = 2;

    localparam int PIdle  = 0;
    localparam int PReq   = 1;
    localparam int PBurst = 2;

    logic                clk_i = 1'b0;
    logic                rst_ni = 1'b0;
    logic [1:0]          req_i = '0;
    logic [1:0]          ack_o;
    logic [1:0][AW-1:0]  addr_i = '0;
    logic [1:0][BW-1:0]  blen_i = '0;
    logic [1:0][1:0]     size_i = '0;
    logic [1:0][IW-1:0]  id_i = '0;
    logic [1:0]          rsp_valid_o;
    logic                rsp_last_o;
    logic [DW-1:0]       rsp_data_o;
    logic [IW-1:0]       rsp_id_o;
    logic                rd_req_o;
    logic                rd_gnt_i = 1'b0;
    logic [AW-1:0]       rd_addr_o;
    logic [BW-1:0]       rd_blen_o;
    logic [1:0]          rd_size_o;
    logic [IW-1:0]       rd_id_o;
    logic                rd_rdy_o;
    logic                rd_valid_i = 1'b0;
    logic                rd_last_i = 1'b0;
    logic [DW-1:0]       rd_data_i = '0;
    logic [IW-1:0]       rd_id_i = '0;
    logic                busy_o;
    logic                stray_o;

    int checks   = 0;
    int failures = 0;

    // Reference model state (transaction level)
    int            m_phase;
    int            m_cur;
    int            m_last_srv;
    int            m_left;
    logic [1:0]    m_pend;
    logic [AW-1:0] m_addr [2];
    logic [BW-1:0] m_blen [2];
    logic [1:0]    m_size [2];
    logic [IW-1:0] m_id   [2];
    int            acc_cnt;
    int            done_cnt;

    always #5 clk_i = ~clk_i;

    cva6_axi_rd_arbiter #(
        .AddrWidth (AW),
        .DataWidth (DW),
        .IdWidth   (IW),
        .BlenWidth (BW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .ack_o       (ack_o),
        .addr_i      (addr_i),
        .blen_i      (blen_i),
        .size_i      (size_i),
        .id_i        (id_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_last_o  (rsp_last_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_id_o    (rsp_id_o),
        .rd_req_o    (rd_req_o),
        .rd_gnt_i    (rd_gnt_i),
        .rd_addr_o   (rd_addr_o),
        .rd_blen_o   (rd_blen_o),
        .rd_size_o   (rd_size_o),
        .rd_id_o     (rd_id_o),
        .rd_rdy_o    (rd_rdy_o),
        .rd_valid_i  (rd_valid_i),
        .rd_last_i   (rd_last_i),
        .rd_data_i   (rd_data_i),
        .rd_id_i     (rd_id_i),
        .busy_o      (busy_o),
        .stray_o     (stray_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic do_req(input int p, input logic [AW-1:0] a, input logic [BW-1:0] bl,
                          input logic [1:0] sz, input logic [IW-1:0] id);
        req_i[p]  = 1'b1;
        addr_i[p] = a;
        blen_i[p] = bl;
        size_i[p] = sz;
        id_i[p]   = id;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (rd_req_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, ".req_seen"}, 64'(rd_req_o), 64'd1);
    endtask

    // Drives blen+1 beats starting in the current cycle, checking routing.
    task automatic send_beats(input int p, input logic [BW-1:0] bl, input logic [IW-1:0] id,
                              input string tag);
        logic [63:0] d;
        logic [1:0]  ev;
        ev = 2'b01 << p;
        chk({tag, ".rdy"}, 64'(rd_rdy_o), 64'd1);
        for (int b = 0; b <= int'(bl); b++) begin
            d          = {$urandom, $urandom};
            rd_valid_i = 1'b1;
            rd_last_i  = (b == int'(bl));
            rd_data_i  = d;
            rd_id_i    = id;
            #1;
            chk({tag, ".rsp_valid"}, 64'(rsp_valid_o), 64'(ev));
            chk({tag, ".rsp_last"}, 64'(rsp_last_o), 64'(b == int'(bl)));
            chk({tag, ".rsp_data"}, rsp_data_o, d);
            chk({tag, ".rsp_id"}, 64'(rsp_id_o), 64'(id));
            tick();
        end
        rd_valid_i = 1'b0;
        rd_last_i  = 1'b0;
    endtask

    task automatic run_burst(input int p, input logic [AW-1:0] a, input logic [BW-1:0] bl,
                             input logic [1:0] sz, input logic [IW-1:0] id, input string tag);
        wait_req(tag);
        chk({tag, ".addr"}, rd_addr_o, a);
        chk({tag, ".blen"}, 64'(rd_blen_o), 64'(bl));
        chk({tag, ".size"}, 64'(rd_size_o), 64'(sz));
        chk({tag, ".id"}, 64'(rd_id_o), 64'(id));
        rd_gnt_i = 1'b1;
        tick();
        rd_gnt_i = 1'b0;
        send_beats(p, bl, id, tag);
    endtask

    task automatic reset_dut();
        req_i      = '0;
        rd_gnt_i   = 1'b0;
        rd_valid_i = 1'b0;
        rd_last_i  = 1'b0;
        rst_ni     = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    // One randomized cycle, checked against the reference model.
    task automatic rand_cycle(input bit allow_req);
        logic [1:0] pend_s;
        logic [1:0] exp_rv;
        for (int i = 0; i < 2; i++) begin
            req_i[i]  = allow_req && ($urandom_range(3) == 0);
            addr_i[i] = {$urandom, $urandom};
            blen_i[i] = BW'($urandom_range(3));
            size_i[i] = 2'($urandom_range(3));
            id_i[i]   = IW'($urandom_range(15));
        end
        rd_gnt_i = (m_phase == PReq) && ($urandom_range(1) == 1);
        if (m_phase == PBurst) begin
            rd_valid_i = ($urandom_range(1) == 1);
            rd_last_i  = rd_valid_i && (m_left == 1);
        end else begin
            rd_valid_i = ($urandom_range(15) == 0);
            rd_last_i  = ($urandom_range(1) == 1);
        end
        rd_data_i = {$urandom, $urandom};
        rd_id_i   = IW'($urandom_range(15));
        #1;

        chk("rand.ack", 64'(ack_o), 64'(req_i & ~m_pend));
        chk("rand.rd_req", 64'(rd_req_o), 64'(m_phase == PReq));
        chk("rand.rd_rdy", 64'(rd_rdy_o), 64'(m_phase == PBurst));
        if (m_phase == PReq) begin
            chk("rand.rd_addr", rd_addr_o, m_addr[m_cur]);
            chk("rand.rd_blen", 64'(rd_blen_o), 64'(m_blen[m_cur]));
            chk("rand.rd_size", 64'(rd_size_o), 64'(m_size[m_cur]));
            chk("rand.rd_id", 64'(rd_id_o), 64'(m_id[m_cur]));
        end
        exp_rv = (m_phase == PBurst && rd_valid_i) ? (2'b01 << m_cur) : 2'b00;
        chk("rand.rsp_valid", 64'(rsp_valid_o), 64'(exp_rv));
        chk("rand.stray", 64'(stray_o), 64'(rd_valid_i && m_phase != PBurst));
        chk("rand.busy", 64'(busy_o), 64'(m_phase != PIdle || m_pend != 2'b00));
        if (m_phase == PBurst && rd_valid_i) begin
            chk("rand.rsp_data", rsp_data_o, rd_data_i);
            chk("rand.rsp_last", 64'(rsp_last_o), 64'(rd_last_i));
            if (rsp_last_o === 1'b1 && rsp_valid_o != 2'b00) done_cnt++;
        end

        pend_s = m_pend;
        case (m_phase)
            PIdle: begin
                if (pend_s != 2'b00) begin
                    m_phase = PReq;
                    if (pend_s == 2'b11) m_cur = (m_last_srv == 0) ? 1 : 0;
                    else                 m_cur = pend_s[1] ? 1 : 0;
                end
            end
            PReq: begin
                if (rd_gnt_i) begin
                    m_phase       = PBurst;
                    m_left        = int'(m_blen[m_cur]) + 1;
                    m_pend[m_cur] = 1'b0;
                end
            end
            default: begin
                if (rd_valid_i) begin
                    m_left--;
                    if (rd_last_i) begin
                        m_phase    = PIdle;
                        m_last_srv = m_cur;
                    end
                end
            end
        endcase
        for (int i = 0; i < 2; i++) begin
            if (req_i[i] && !pend_s[i]) begin
                m_pend[i] = 1'b1;
                m_addr[i] = addr_i[i];
                m_blen[i] = blen_i[i];
                m_size[i] = size_i[i];
                m_id[i]   = id_i[i];
                acc_cnt++;
            end
        end
        tick();
    endtask

    initial begin
        int n;

        // Reset state
        rst_ni = 1'b0;
        tick();
        tick();
        chk("reset.rd_req", 64'(rd_req_o), 64'd0);
        chk("reset.rd_rdy", 64'(rd_rdy_o), 64'd0);
        chk("reset.ack", 64'(ack_o), 64'd0);
        chk("reset.rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("reset.busy", 64'(busy_o), 64'd0);
        chk("reset.stray", 64'(stray_o), 64'd0);
        rst_ni = 1'b1;

        // Single request: ack same cycle, rd_req two cycles later
        do_req(0, 64'h0000_0000_8000_0000, 2'd1, 2'd3, 4'd5);
        #1;
        chk("single.ack", 64'(ack_o), 64'b01);
        tick();
        req_i = '0;
        #1;
        chk("single.rd_req_n1", 64'(rd_req_o), 64'd0);
        chk("single.busy_n1", 64'(busy_o), 64'd1);
        tick();
        chk("single.rd_req_n2", 64'(rd_req_o), 64'd1);
        run_burst(0, 64'h0000_0000_8000_0000, 2'd1, 2'd3, 4'd5, "single");
        chk("single.idle_rdy", 64'(rd_rdy_o), 64'd0);
        chk("single.idle_busy", 64'(busy_o), 64'd0);

        // Simultaneous requests: port 0 first after reset, and again next round
        reset_dut();
        for (int r = 0; r < 2; r++) begin
            do_req(0, 64'h1000 + 64'(r), 2'd0, 2'd2, 4'd1);
            do_req(1, 64'h2000 + 64'(r), 2'd1, 2'd3, 4'd2);
            #1;
            chk("simul.ack", 64'(ack_o), 64'b11);
            tick();
            req_i = '0;
            run_burst(0, 64'h1000 + 64'(r), 2'd0, 2'd2, 4'd1, "simul.p0");
            run_burst(1, 64'h2000 + 64'(r), 2'd1, 2'd3, 4'd2, "simul.p1");
        end

        // Grant back-pressure: request held 6 cycles, second port-0 request blocked
        do_req(0, 64'hA000, 2'd1, 2'd1, 4'd7);
        tick();
        req_i = '0;
        tick();
        for (int k = 0; k < 6; k++) begin
            chk("bp.rd_req", 64'(rd_req_o), 64'd1);
            chk("bp.rd_addr", rd_addr_o, 64'hA000);
            if (k >= 2) begin
                do_req(0, 64'hB000, 2'd2, 2'd0, 4'd8);
                #1;
                chk("bp.ack_blocked", 64'(ack_o), 64'b00);
            end
            if (k == 5) rd_gnt_i = 1'b1;
            tick();
        end
        rd_gnt_i = 1'b0;
        #1;
        chk("bp.ack_after_gnt", 64'(ack_o), 64'b01);
        tick();
        req_i = '0;
        send_beats(0, 2'd1, 4'd7, "bp.a");
        run_burst(0, 64'hB000, 2'd2, 2'd0, 4'd8, "bp.b");

        // Bypass single beat on port 1
        do_req(1, 64'hC000, 2'd0, 2'd3, 4'd3);
        tick();
        req_i = '0;
        run_burst(1, 64'hC000, 2'd0, 2'd3, 4'd3, "bypass");
        chk("bypass.busy", 64'(busy_o), 64'd0);

        // Stray beat in IDLE
        rd_valid_i = 1'b1;
        rd_last_i  = 1'b1;
        #1;
        chk("stray.pulse", 64'(stray_o), 64'd1);
        chk("stray.rsp_valid", 64'(rsp_valid_o), 64'd0);
        tick();
        rd_valid_i = 1'b0;
        rd_last_i  = 1'b0;
        #1;
        chk("stray.clear", 64'(stray_o), 64'd0);

        // Reset mid-burst after beat 1 of 4
        do_req(0, 64'hD000, 2'd3, 2'd3, 4'd9);
        tick();
        req_i = '0;
        wait_req("rstmid");
        rd_gnt_i = 1'b1;
        tick();
        rd_gnt_i   = 1'b0;
        rd_valid_i = 1'b1;
        rd_data_i  = 64'h1111;
        #1;
        chk("rstmid.beat1", 64'(rsp_valid_o), 64'b01);
        tick();
        rd_valid_i = 1'b0;
        rst_ni     = 1'b0;
        tick();
        rst_ni = 1'b1;
        #1;
        chk("rstmid.rd_req", 64'(rd_req_o), 64'd0);
        chk("rstmid.busy", 64'(busy_o), 64'd0);
        for (int b = 0; b < 3; b++) begin
            rd_valid_i = 1'b1;
            rd_last_i  = (b == 2);
            #1;
            chk("rstmid.stray", 64'(stray_o), 64'd1);
            chk("rstmid.rsp_valid", 64'(rsp_valid_o), 64'd0);
            tick();
        end
        rd_valid_i = 1'b0;
        rd_last_i  = 1'b0;

        // Randomized traffic against the reference model
        reset_dut();
        m_phase    = PIdle;
        m_cur      = 0;
        m_last_srv = 1;
        m_left     = 0;
        m_pend     = 2'b00;
        acc_cnt    = 0;
        done_cnt   = 0;
        for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
        n = 0;
        while ((m_phase != PIdle || m_pend != 2'b00) && n < 400) begin
            rand_cycle(1'b0);
            n++;
        end
        req_i = '0;
        rd_valid_i = 1'b0;
        rd_gnt_i = 1'b0;
        #1;
        chk("rand.drain_busy", 64'(busy_o), 64'd0);
        chk("rand.bursts", 64'(done_cnt), 64'(acc_cnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
